// File: rtl/player_shot_ctrl.sv
// Player bullet pool: spawns shots on the fire key with a cooldown,
// moves live shots up once per frame and retires them at the top edge.
module player_shot_ctrl #(
  parameter int         NUM_SHOTS  = 8,
  parameter logic [9:0] SHOT_SPEED = 10'd4,
  parameter logic [9:0] SHOT_Y_OFF = 10'd8,
  parameter int         COOLDOWN   = 6,
  parameter logic [7:0] FIRE_KEY   = 8'h1D
) (
  input  logic                          frame_clk,
  input  logic                          Reset,
  input  logic [7:0]                    keycode,
  input  logic [9:0]                    PlayerX,
  input  logic [9:0]                    PlayerY,
  output logic [10*NUM_SHOTS-1:0]       ShotX,
  output logic [10*NUM_SHOTS-1:0]       ShotY,
  output logic [NUM_SHOTS-1:0]          ShotActive,
  output logic [$clog2(NUM_SHOTS+1)-1:0] ShotCount,
  output logic                          FireEvent
);

  localparam int CW = $clog2(NUM_SHOTS + 1);
  localparam int DW = $clog2(COOLDOWN + 2);

  logic [NUM_SHOTS-1:0][9:0] r_x;
  logic [NUM_SHOTS-1:0][9:0] r_y;
  logic [NUM_SHOTS-1:0][9:0] w_x_nxt;
  logic [NUM_SHOTS-1:0][9:0] w_y_nxt;
  logic [NUM_SHOTS-1:0]      r_act;
  logic [NUM_SHOTS-1:0]      w_act_nxt;
  logic [NUM_SHOTS-1:0]      w_sel;
  logic [CW-1:0]             r_cnt;
  logic [CW-1:0]             w_cnt_nxt;
  logic [DW-1:0]             r_cd;
  logic [DW-1:0]             w_cd_nxt;
  logic                      r_fire;
  logic                      w_spawn;
  logic                      w_found;
  logic [9:0]                w_spawn_y;

  always_comb begin
    w_sel     = '0;
    w_found   = 1'b0;
    w_spawn_y = (PlayerY < SHOT_Y_OFF) ? 10'd0 : PlayerY - SHOT_Y_OFF;
    // lowest-index slot that was free before this edge
    for (int i = 0; i < NUM_SHOTS; i++) begin
      if (!r_act[i] && !w_found) begin
        w_sel[i] = 1'b1;
        w_found  = 1'b1;
      end
    end
    w_spawn = (keycode == FIRE_KEY) && (r_cd == '0) && w_found;

    w_act_nxt = r_act;
    w_x_nxt   = r_x;
    w_y_nxt   = r_y;
    for (int i = 0; i < NUM_SHOTS; i++) begin
      if (r_act[i]) begin
        if (r_y[i] < SHOT_SPEED) w_act_nxt[i] = 1'b0;
        else                     w_y_nxt[i]   = r_y[i] - SHOT_SPEED;
      end else if (w_spawn && w_sel[i]) begin
        w_act_nxt[i] = 1'b1;
        w_x_nxt[i]   = PlayerX;
        w_y_nxt[i]   = w_spawn_y;
      end
    end

    w_cnt_nxt = '0;
    for (int i = 0; i < NUM_SHOTS; i++)
      w_cnt_nxt = w_cnt_nxt + CW'(w_act_nxt[i]);

    if (w_spawn)          w_cd_nxt = DW'(COOLDOWN);
    else if (r_cd != '0)  w_cd_nxt = r_cd - DW'(1);
    else                  w_cd_nxt = r_cd;
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_x    <= '0;
      r_y    <= '0;
      r_act  <= '0;
      r_cnt  <= '0;
      r_cd   <= '0;
      r_fire <= 1'b0;
    end else begin
      r_x    <= w_x_nxt;
      r_y    <= w_y_nxt;
      r_act  <= w_act_nxt;
      r_cnt  <= w_cnt_nxt;
      r_cd   <= w_cd_nxt;
      r_fire <= w_spawn;
    end
  end

  assign ShotX      = r_x;
  assign ShotY      = r_y;
  assign ShotActive = r_act;
  assign ShotCount  = r_cnt;
  assign FireEvent  = r_fire;

endmodule
